// File: rtl/sum_fact_pkg.sv
// Shared definitions for the sum-of-factorials result path: FSM encodings
// (matching the upstream stage's style) and the default result geometry.
package sum_fact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b11
  } state_t;

  // 13 bits covers every real upstream result (max 5913); four BCD digits
  // cover the whole 13-bit range (max 8191 < 10^4).
  localparam int DEF_WIDTH  = 13;
  localparam int DEF_DIGITS = 4;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Purely combinational correction of one digit
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/sum_fact_bcd.sv
// Binary-to-packed-BCD converter sitting behind the sum-of-factorials stage.
// Captures one upstream result per handshake, runs a shift-and-add-3
// conversion for WIDTH cycles, then holds the BCD result until the
// downstream consumer acknowledges it. 10^DIGITS must exceed 2^WIDTH-1.
module sum_fact_bcd
  import sum_fact_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      sum_fact,
  input  logic                  sum_valid,
  output logic                  sum_ack,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  input  logic                  bcd_ack
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_capture;
  logic                w_shift;
  logic                w_last;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_acc;
  logic [4*DIGITS-1:0] w_acc_corr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sum_ack;

  // Per-digit add-3 correction applied before every shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_acc_corr[4*g +: 4])
    );
  end

  assign w_last = (r_cnt == LAST_CNT);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath strobes; sum_valid only matters in IDLE,
  // bcd_ack only in DONE
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (sum_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bcd_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register, BCD accumulator and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_shift <= sum_fact;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_acc   <= {w_acc_corr[4*DIGITS-2:0], r_shift[WIDTH-1]};
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Acknowledge lasts exactly the cycle after capture; capture only happens
  // from IDLE and CONV always follows, so it can never repeat back to back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum_ack <= 1'b0;
    end else begin
      r_sum_ack <= w_capture;
    end
  end

  assign sum_ack   = r_sum_ack;
  assign bcd_valid = (r_state == DONE);
  assign bcd       = bcd_valid ? r_acc : '0;

endmodule

// File: tb/tb_sum_fact_bcd.sv
// Self-checking bench for sum_fact_bcd: scoreboard of expected BCD values
// filled on each observed capture and drained on each completed conversion.
module tb_sum_fact_bcd;

  localparam int WIDTH  = 13;
  localparam int DIGITS = 4;
  localparam int LAT    = 13;

  logic                clk;
  logic                reset;
  logic [WIDTH-1:0]    sum_fact;
  logic                sum_valid;
  logic                sum_ack;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;
  logic                bcd_ack;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  logic [4*DIGITS-1:0] sb_q[$];

  sum_fact_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .sum_fact  (sum_fact),
    .sum_valid (sum_valid),
    .sum_ack   (sum_ack),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .bcd_ack   (bcd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sum_ack === 1'b1) ack_cnt++;
  end

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int sum_of_fact(input int n);
    int s;
    int f;
    s = 0;
    f = 1;
    for (int k = 1; k <= n; k++) begin
      f = f * k;
      s = s + f;
    end
    return s;
  endfunction

  // Offer a value until sum_ack appears; on return we sit 1ns after the
  // edge following capture. ok=0 means no acknowledge within the budget.
  task automatic send(input int v, output bit ok);
    ok = 1'b0;
    sum_fact  = WIDTH'(v);
    sum_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sum_ack === 1'b1) begin
        ok = 1'b1;
        sb_q.push_back(to_bcd(v));
        break;
      end
    end
    sum_valid = 1'b0;
  endtask

  // Wait (bounded) for bcd_valid, returning edges elapsed
  task automatic wait_valid(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bcd_valid === 1'b1) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    bcd_ack = 1'b1;
    @(posedge clk); #1;
    bcd_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    sum_fact  = '0;
    sum_valid = 1'b0;
    bcd_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({sum_ack, bcd_valid, bcd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b valid=%b bcd=%h, required 0 0 0000",
               sum_ack, bcd_valid, bcd);
    end
    reset = 1'b1;
    bcd_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bcd_ack = 1'b0;
    n_assert++;
    if ({sum_ack, bcd_valid, bcd} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ack=%b valid=%b bcd=%h, required 0 0 0000",
               sum_ack, bcd_valid, bcd);
    end
  endtask

  task automatic test_convert(input int v, input bit ack_in_conv);
    bit ok;
    int lat;
    int extra;
    logic [4*DIGITS-1:0] exp;
    send(v, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL capture_%0d: no sum_ack seen, required one", v);
      return;
    end
    @(posedge clk); #1;
    extra = 1;
    n_assert++;
    if (sum_ack !== 1'b0 || bcd_valid !== 1'b0 || bcd !== '0) begin
      n_fail++;
      $display("FAIL conv_outputs_%0d: ack=%b valid=%b bcd=%h, required 0 0 0000",
               v, sum_ack, bcd_valid, bcd);
    end
    if (ack_in_conv) begin
      bcd_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bcd_ack = 1'b0;
      extra += 3;
    end
    wait_valid(lat, ok);
    n_assert++;
    if (!ok || (lat + extra) != LAT) begin
      n_fail++;
      $display("FAIL latency_%0d: got %0d cycles (seen=%0d), required %0d",
               v, lat + extra, ok, LAT);
    end
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    n_assert++;
    if (bcd !== exp) begin
      n_fail++;
      $display("FAIL value_%0d: bcd=%h, required %h", v, bcd, exp);
    end
    pulse_ack();
    n_assert++;
    if (bcd_valid !== 1'b0 || bcd !== '0) begin
      n_fail++;
      $display("FAIL release_%0d: valid=%b bcd=%h, required 0 0000", v, bcd_valid, bcd);
    end
  endtask

  task automatic test_ack_withheld();
    bit ok;
    int lat;
    int acks0;
    int bad;
    logic [4*DIGITS-1:0] exp;
    send(1234, ok);
    wait_valid(lat, ok);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    n_assert++;
    if (!ok || bcd !== exp) begin
      n_fail++;
      $display("FAIL hold_first: valid=%0d bcd=%h, required 1 %h", ok, bcd, exp);
    end
    acks0 = ack_cnt;
    sum_fact  = WIDTH'(777);
    sum_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ({bcd_valid, sum_ack, bcd} !== {1'b1, 1'b0, exp}) bad++;
    end
    n_assert++;
    if (bad != 0 || ack_cnt != acks0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles, %0d acks, required 0 0",
               bad, ack_cnt - acks0);
    end
    pulse_ack();
    n_assert++;
    if (bcd_valid !== 1'b0 || sum_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: valid=%b ack=%b, required 0 0", bcd_valid, sum_ack);
    end
    @(posedge clk); #1;
    n_assert++;
    if (sum_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_capture: ack=%b, required 1", sum_ack);
    end else begin
      sb_q.push_back(to_bcd(777));
    end
    sum_valid = 1'b0;
    wait_valid(lat, ok);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    n_assert++;
    if (!ok || lat != LAT || bcd !== exp || ack_cnt != acks0 + 1) begin
      n_fail++;
      $display("FAIL hold_second: lat=%0d bcd=%h acks=%0d, required %0d %h 1",
               lat, bcd, ack_cnt - acks0, LAT, exp);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    int acks0;
    logic [4*DIGITS-1:0] exp;
    acks0 = ack_cnt;
    send(33, ok);
    wait_valid(lat, ok);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    n_assert++;
    if (!ok || bcd !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%0d bcd=%h, required 1 %h", ok, bcd, exp);
    end
    bcd_ack   = 1'b1;
    sum_fact  = WIDTH'(153);
    sum_valid = 1'b1;
    @(posedge clk); #1;
    bcd_ack = 1'b0;
    n_assert++;
    if (bcd_valid !== 1'b0 || sum_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: valid=%b ack=%b, required 0 0", bcd_valid, sum_ack);
    end
    @(posedge clk); #1;
    n_assert++;
    if (sum_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_capture: ack=%b, required 1", sum_ack);
    end else begin
      sb_q.push_back(to_bcd(153));
    end
    sum_valid = 1'b0;
    wait_valid(lat, ok);
    exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
    n_assert++;
    if (!ok || lat != LAT || bcd !== exp || ack_cnt != acks0 + 2) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d bcd=%h acks=%0d, required %0d %h 2",
               lat, bcd, ack_cnt - acks0, LAT, exp);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_conv();
    bit ok;
    int bad;
    int acks0;
    send(5913, ok);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_assert++;
    if ({sum_ack, bcd_valid, bcd} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: ack=%b valid=%b bcd=%h, required 0 0 0000",
               sum_ack, bcd_valid, bcd);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    acks0 = ack_cnt;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bcd_valid !== 1'b0 || bcd !== '0) bad++;
    end
    n_assert++;
    if (bad != 0 || ack_cnt != acks0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d valid cycles, %0d acks, required 0 0",
               bad, ack_cnt - acks0);
    end
  endtask

  task automatic test_end_to_end();
    for (int n = 0; n <= 7; n++) begin
      test_convert(sum_of_fact(n), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_convert(5913, 1'b0);
    test_convert(0, 1'b0);
    test_convert(8191, 1'b1);
    test_convert(4999, 1'b0);
    test_ack_withheld();
    test_back_to_back();
    test_reset_mid_conv();
    test_convert(42, 1'b0);
    test_end_to_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_fact_bcd.md
SUM_FACT_BCD -- requirements
Module: sum_fact_bcd

Interface
REQ-001 Parameter WIDTH, default 13: binary result width accepted from the sum-of-factorials stage.
REQ-002 Parameter DIGITS, default 4: number of packed BCD output digits.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 sum_fact  input  WIDTH: binary result from upstream; valid only while sum_valid=1.
REQ-006 sum_valid  input  1: upstream result-valid, connected to upstream output_valid.
REQ-007 sum_ack  output  1: one-cycle capture acknowledge, connected to upstream output_ack.
REQ-008 bcd  output  4*DIGITS: packed BCD result, most significant digit in bits [4*DIGITS-1 : 4*DIGITS-4].
REQ-009 bcd_valid  output  1: bcd holds a completed conversion.
REQ-010 bcd_ack  input  1: downstream consumer has taken bcd.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-012 IDLE with sum_valid=1: the block SHALL, on the next edge, latch sum_fact into a shift register, clear the BCD accumulator and iteration counter, enter CONV, and drive sum_ack=1 for exactly that following cycle.
REQ-013 IDLE with sum_valid=0: the block SHALL hold all state, with sum_ack=0.
REQ-014 CONV: each cycle, every BCD digit >=5 SHALL have 3 added first; the accumulator and shift register SHALL then shift left one bit together, with the shift-register MSB entering accumulator bit 0.
REQ-015 CONV SHALL run exactly WIDTH shift cycles (counter 0..WIDTH-1), then enter DONE; bcd_valid SHALL rise WIDTH cycles after the capture edge (13 for the defaults).
REQ-016 DONE: bcd_valid=1 and bcd SHALL hold the converted value stable until the edge on which bcd_ack=1 is sampled; that edge SHALL return the FSM to IDLE.
REQ-017 bcd SHALL read 0 whenever bcd_valid=0.
REQ-018 sum_valid SHALL be ignored in CONV and DONE, with no sum_ack issued; the upstream result stays pending until IDLE.
REQ-019 bcd_ack SHALL be ignored outside DONE.
REQ-020 sum_ack SHALL never be asserted on two consecutive cycles, so each upstream result is captured exactly once.
REQ-021 Range rule: 10^DIGITS SHALL exceed 2^WIDTH-1; with the defaults, every 13-bit input (max 8191, max real result 5913) SHALL convert without overflow.
REQ-022 Back-to-back: if sum_valid=1 in the first IDLE cycle after DONE, capture SHALL occur at that edge, giving one idle cycle between results.

Reset
REQ-023 reset=0 SHALL asynchronously force: FSM to IDLE, shift register, accumulator and counter to 0, sum_ack=0, bcd_valid=0, bcd=0.
REQ-024 Reset in CONV or DONE SHALL abort the conversion; after reset release, the block SHALL capture nothing until a new sum_valid is seen in IDLE.

Structure
REQ-025 State encodings SHALL live in a shared package sum_fact_pkg, along with default WIDTH/DIGITS constants: IDLE=2'b00, CONV=2'b01, DONE=2'b11, matching the upstream encoding style.
REQ-026 The per-digit "add 3 if >=5" correction SHALL be one combinational sub-module, bcd_add3, instantiated DIGITS times.
REQ-027 All other logic, including the FSM, counter and datapath registers, SHALL reside in sum_fact_bcd.

Verification
REQ-028 sum_fact=5913, sum_valid pulse -> sum_ack for one cycle; 13 cycles later bcd=16'h5913, bcd_valid=1.
REQ-029 sum_fact=0 -> bcd=16'h0000 with bcd_valid=1 after 13 cycles; sum_fact=8191 -> bcd=16'h8191.
REQ-030 bcd_ack withheld 20 cycles while sum_valid=1 with a new value -> bcd stays stable, no sum_ack, no new capture until ack.
REQ-031 Back-to-back 33 then 153 with bcd_ack on the first DONE cycle -> 16'h0033, then 16'h0153, each captured exactly once.
REQ-032 reset=0 at cycle 6 of CONV -> all outputs 0 immediately; after release, no bcd_valid until a new capture.
REQ-033 End-to-end with the upstream sum-of-factorials stage, N_in=0..7 -> bcd=1,3,9,33,153,873,5913 for N=1..7; N=0 checked against the upstream result.
